// File: rtl/therm_pkg.sv
// Shared constants and types for the thermometer-code decoders.
package therm_pkg;

  // Default bar width (10 segments) and the count width able to hold 0..10.
  localparam int DEF_WIDTH = 10;
  localparam int DEF_OUT_W = 4;

  // Decoder FSM: HOLD idles with an accepted code, SETTLE times a new one.
  typedef enum logic {
    HOLD   = 1'b0,
    SETTLE = 1'b1
  } therm_state_t;

  // Value driven onto the error flag for a clean code or a bubbled one.
  localparam logic LEGAL  = 1'b0;
  localparam logic BUBBLE = 1'b1;

endpackage

// File: rtl/therm_code_check.sv
// Combinational thermometer-code checker: reports whether a code has the
// form 0..01..1 (all-zero and all-one included) and its segment count.
module therm_code_check
  import therm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [OUT_W-1:0] count
);

  logic [WIDTH-1:0] code_inc;

  // A run of ones from bit 0 turns into a single carry when incremented, so
  // it shares no set bit with its successor; any bubble leaves an overlap.
  assign code_inc = code + WIDTH'(1);
  assign legal    = ((code & code_inc) == '0);

  // Segment count; only meaningful when the code is legal.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + OUT_W'(code[i]);
    end
  end

endmodule

// File: rtl/therm_2_bin.sv
// Debounced thermometer-to-binary decoder. The raw bar code is synchronized,
// must stay unchanged for STABLE_CYCLES clocks, and is then accepted: a
// legal code updates number, a bubbled code raises error, and valid strobes
// for one cycle. A code that settles back to the last accepted one is silent.
//
// Handshake: valid is a one-cycle strobe with no ready; number and error are
// registered and change only in the cycle valid is high (or on reset).
module therm_2_bin
  import therm_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int OUT_W         = DEF_OUT_W,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] thermometer,
  output logic [OUT_W-1:0] number,
  output logic             valid,
  output logic             error
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] last_code;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  therm_state_t     state;
  therm_state_t     state_n;
  logic             changed;
  logic             accept;
  logic             update;
  logic             legal;
  logic [OUT_W-1:0] count;

  therm_code_check #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_check (
    .code  (sync2),
    .legal (legal),
    .count (count)
  );

  assign changed = (sync2 != prev);
  // An accept that lands back on the stored code is a glitch that recovered.
  assign update  = accept && (sync2 != last_code);

  // Two-flop synchronizer plus one-clock delayed copy for change detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= thermometer;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // FSM state and stability counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HOLD;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: any change restarts settling; a full quiet window accepts.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    if (changed) begin
      cnt_n   = '0;
      state_n = SETTLE;
    end else if (state == SETTLE) begin
      if (cnt == CNT_LAST) begin
        accept  = 1'b1;
        state_n = HOLD;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
  end

  // Output registers: a bubble keeps the old number but flags error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      number    <= '0;
      valid     <= 1'b0;
      error     <= LEGAL;
      last_code <= '0;
    end else begin
      valid <= update;
      if (update) begin
        last_code <= sync2;
        error     <= legal ? LEGAL : BUBBLE;
        if (legal) begin
          number <= count;
        end
      end
    end
  end

endmodule
